sram_track_mixer: RTL and testbench



---
 rtl/mixer_pkg.sv | 16 +
 rtl/sample_saturate.sv | 25 ++
 rtl/sram_track_mixer.sv | 175 +++++++++++++++++
 tb/tb_sram_track_mixer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared types and defaults for the SRAM track mixers: FSM states,
// accumulator sizing and the default SRAM track layout.
package mixer_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, FETCH, EMIT} mixerState_e;

  localparam logic [19:0] DEF_BASE_ADDR    = 20'h20000;
  localparam logic [19:0] DEF_TRACK_STRIDE = 20'h20000;
  localparam logic [19:0] DEF_TRACK_LEN    = 20'h20000;

  // One guard bit per doubling of the track count plus one spare.
  function automatic int accWidth(input int dataW, input int numTracks);
    return dataW + $clog2(numTracks) + 1;
  endfunction

endpackage

// File: rtl/sample_saturate.sv
// Combinational clamp of a wide signed sum into a narrower signed sample.
module sample_saturate #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  logic [IN_W-OUT_W:0] topBits;

  assign topBits = in_i[IN_W-1:OUT_W-1];

  // The value fits when every bit above the output sign equals that sign.
  always_comb begin
    if (topBits == '0 || topBits == '1) begin
      out_o = in_i[OUT_W-1:0];
    end else if (in_i[IN_W-1]) begin
      out_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      out_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/sram_track_mixer.sv
// Multi-track playback engine: once per frame edge it fetches one sample per
// track from SRAM at the shared play position and emits the saturated sum.
module sram_track_mixer
  import mixer_pkg::*;
#(
  parameter int                NUM_TRACKS   = 4,
  parameter int                ADDR_W       = 20,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] TRACK_LEN    = ADDR_W'(DEF_TRACK_LEN),
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] TRACK_STRIDE = ADDR_W'(DEF_TRACK_STRIDE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_loop,
  input  logic [NUM_TRACKS-1:0] i_track_en,
  input  logic                  i_frame,
  output logic [ADDR_W-1:0]     o_sram_addr,
  input  logic [DATA_W-1:0]     i_sram_dq,
  output logic [DATA_W-1:0]     o_sample,
  output logic                  o_sample_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overrun,
  output logic [ADDR_W-1:0]     o_pos
);

  localparam int                ACC_W    = accWidth(DATA_W, NUM_TRACKS);
  localparam int                CNT_W    = $clog2(NUM_TRACKS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_TRACKS);
  localparam logic [ADDR_W-1:0] LAST_POS = TRACK_LEN - ADDR_W'(1);

  mixerState_e           state_q, state_d;
  logic                  frameLvl_q;
  logic [CNT_W-1:0]      fetchCnt_q, fetchCnt_d;
  logic [NUM_TRACKS-1:0] trackEn_q, trackEn_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DATA_W-1:0]     sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [ADDR_W-1:0]     pos_q, pos_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     satSample;
  logic [ACC_W-1:0]      dqExt;
  logic                  frameEdge;

  assign frameEdge = i_frame & ~frameLvl_q;
  assign dqExt     = {{(ACC_W-DATA_W){i_sram_dq[DATA_W-1]}}, i_sram_dq};

  sample_saturate #(
    .IN_W (ACC_W),
    .OUT_W(DATA_W)
  ) u_sat (
    .in_i (acc_d),
    .out_o(satSample)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      frameLvl_q <= 1'b0;
      fetchCnt_q <= '0;
      trackEn_q  <= '0;
      acc_q      <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      pos_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      frameLvl_q <= i_frame;
      fetchCnt_q <= fetchCnt_d;
      trackEn_q  <= trackEn_d;
      acc_q      <= acc_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      pos_q      <= pos_d;
      addr_q     <= addr_d;
    end
  end

  // Data for track k arrives in fetch cycle k+1; the enable mask is shifted
  // alongside so bit 0 always belongs to the sample currently on the bus.
  always_comb begin
    state_d    = state_q;
    fetchCnt_d = fetchCnt_q;
    trackEn_d  = trackEn_q;
    acc_d      = acc_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    overrun_d  = 1'b0;
    pos_d      = pos_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = WAIT;
          pos_d   = '0;
        end
      end
      WAIT: begin
        if (frameEdge) begin
          state_d    = FETCH;
          fetchCnt_d = '0;
          acc_d      = '0;
          trackEn_d  = i_track_en;
        end
      end
      FETCH: begin
        overrun_d = frameEdge;
        if (fetchCnt_q != '0) begin
          if (trackEn_q[0]) acc_d = acc_q + dqExt;
          trackEn_d = trackEn_q >> 1;
        end
        if (fetchCnt_q == LAST_CNT) begin
          state_d  = EMIT;
          sample_d = satSample;
          valid_d  = 1'b1;
          if (pos_q != LAST_POS) begin
            pos_d = pos_q + ADDR_W'(1);
          end else begin
            pos_d  = '0;
            done_d = ~i_loop;
          end
        end else begin
          fetchCnt_d = fetchCnt_q + CNT_W'(1);
        end
      end
      EMIT: begin
        overrun_d = frameEdge;
        state_d   = done_q ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (i_start && state_q != IDLE) begin
      state_d  = WAIT;
      pos_d    = '0;
      sample_d = sample_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;
    end
    if (i_stop) begin
      state_d  = IDLE;
      pos_d    = '0;
      sample_d = sample_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;
    end
  end

  // The address is registered from next-state values so it still lines up
  // with the fetch cycle while reading 0 during reset.
  always_comb begin
    addr_d = BASE_ADDR + pos_d;
    if (state_d == FETCH && fetchCnt_d != LAST_CNT) begin
      addr_d = BASE_ADDR + ADDR_W'(fetchCnt_d) * TRACK_STRIDE + pos_d;
    end
  end

  assign o_sram_addr    = addr_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;
  assign o_busy         = (state_q != IDLE);
  assign o_done         = done_q;
  assign o_overrun      = overrun_q;
  assign o_pos          = pos_q;

endmodule

// File: tb/tb_sram_track_mixer.sv
// Scoreboard bench for sram_track_mixer with a 4-entry track length so that
// end-of-track, loop, stop, restart, overrun and reset paths are all reached.
module tb_sram_track_mixer;

  typedef struct {
    logic [15:0] sample;
    logic [19:0] pos;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loopMode = 1'b1;
  logic [3:0]  trackEn = 4'hF;
  logic        frame = 1'b0;
  logic [19:0] sramAddr;
  logic [15:0] sramDq = '0;
  logic [15:0] sample;
  logic        sampleValid, busy, done, overrun;
  logic [19:0] pos;

  logic [15:0] trackVal [4];
  logic [19:0] benchPos = '0;
  exp_t        expQ[$];
  int          checks = 0;
  int          failures = 0;

  sram_track_mixer #(
    .NUM_TRACKS(4),
    .ADDR_W(20),
    .DATA_W(16),
    .TRACK_LEN(20'd4),
    .BASE_ADDR(20'h20000),
    .TRACK_STRIDE(20'h20000)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_stop(stop),
    .i_loop(loopMode),
    .i_track_en(trackEn),
    .i_frame(frame),
    .o_sram_addr(sramAddr),
    .i_sram_dq(sramDq),
    .o_sample(sample),
    .o_sample_valid(sampleValid),
    .o_busy(busy),
    .o_done(done),
    .o_overrun(overrun),
    .o_pos(pos)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, track index decoded from the address.
  always @(posedge clk) begin
    logic [19:0] off;
    int idx;
    off = sramAddr - 20'h20000;
    idx = int'(off / 20'h20000);
    if (idx >= 0 && idx < 4) sramDq <= trackVal[idx];
    else sramDq <= 16'h0000;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setTracks(input logic [15:0] v0, input logic [15:0] v1,
                           input logic [15:0] v2, input logic [15:0] v3);
    trackVal[0] = v0;
    trackVal[1] = v1;
    trackVal[2] = v2;
    trackVal[3] = v3;
  endtask

  task automatic pulseCtl(input logic s, input logic p);
    @(posedge clk);
    #1;
    start = s;
    stop  = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // One full frame: push the hand-computed result, raise the frame, check
  // fetch addresses, latency and overrun count, then hold the frame low.
  task automatic applyStimulus(input logic [15:0] expSample, input logic [19:0] expPos,
                               input logic expDone, input logic inject);
    exp_t e;
    int lat;
    int ovr;
    logic [19:0] expAddr;
    e.sample = expSample;
    e.pos    = expPos;
    e.done   = expDone;
    expQ.push_back(e);
    lat = 0;
    ovr = 0;
    @(posedge clk);
    #1;
    frame = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (inject && i == 2) frame = 1'b0;
      if (inject && i == 3) frame = 1'b1;
      if (i <= 4) begin
        expAddr = 20'h20000 + 20'(i - 1) * 20'h20000 + benchPos;
        checkOutput("fetch_addr", 32'(sramAddr), 32'(expAddr));
      end
      if (overrun) ovr++;
      if (sampleValid) begin
        lat = i;
        break;
      end
    end
    checkOutput("latency", lat, 6);
    checkOutput("overrun_count", ovr, inject ? 1 : 0);
    benchPos = expPos;
    repeat (2) @(negedge clk);
    frame = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Monitor: every valid pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sampleValid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_valid: got sample 0x%0h with no expected entry", sample);
        end else begin
          e = expQ.pop_front();
          checkOutput("sample", 32'(sample), 32'(e.sample));
          checkOutput("pos", 32'(pos), 32'(e.pos));
          checkOutput("done", 32'(done), 32'(e.done));
        end
      end else if (done) begin
        checks++;
        failures++;
        $display("[TB] FAIL done_without_valid: got done=1 expected 0");
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    setTracks(16'd100, 16'd200, 16'd300, 16'd400);
    repeat (3) @(negedge clk);
    checkOutput("rst_sample", 32'(sample), 0);
    checkOutput("rst_valid", 32'(sampleValid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_pos", 32'(pos), 0);
    checkOutput("rst_addr", 32'(sramAddr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Looping playback through saturation, masking and the position wrap.
    loopMode = 1'b1;
    pulseCtl(1'b1, 1'b0);
    checkOutput("busy_after_start", 32'(busy), 1);
    benchPos = '0;
    applyStimulus(16'd1000, 20'd1, 1'b0, 1'b0);
    setTracks(16'h7000, 16'h7000, 16'h7000, 16'h7000);
    applyStimulus(16'h7FFF, 20'd2, 1'b0, 1'b0);
    setTracks(16'h9000, 16'h9000, 16'h9000, 16'h9000);
    applyStimulus(16'h8000, 20'd3, 1'b0, 1'b0);
    setTracks(16'd100, 16'd200, 16'd300, 16'd400);
    trackEn = 4'b0101;
    applyStimulus(16'd400, 20'd0, 1'b0, 1'b0);
    trackEn = 4'hF;
    applyStimulus(16'd1000, 20'd1, 1'b0, 1'b0);

    // Restart while busy returns the position to 0.
    pulseCtl(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("restart_pos", 32'(pos), 0);
    checkOutput("restart_busy", 32'(busy), 1);
    benchPos = '0;

    // Non-looping run to the end of the track.
    loopMode = 1'b0;
    applyStimulus(16'd1000, 20'd1, 1'b0, 1'b0);
    applyStimulus(16'd1000, 20'd2, 1'b0, 1'b0);
    applyStimulus(16'd1000, 20'd3, 1'b0, 1'b0);
    applyStimulus(16'd1000, 20'd0, 1'b1, 1'b0);
    checkOutput("idle_after_end", 32'(busy), 0);

    // Stop mid-fetch: no valid, previous sample held, position cleared.
    loopMode = 1'b1;
    pulseCtl(1'b1, 1'b0);
    benchPos = '0;
    applyStimulus(16'd1000, 20'd1, 1'b0, 1'b0);
    setTracks(16'h7000, 16'h7000, 16'h7000, 16'h7000);
    @(posedge clk);
    #1;
    frame = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    checkOutput("stop_busy", 32'(busy), 0);
    checkOutput("stop_pos", 32'(pos), 0);
    checkOutput("stop_sample_hold", 32'(sample), 1000);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (sampleValid) seen++;
    end
    checkOutput("stop_no_valid", seen, 0);
    frame = 1'b0;
    repeat (4) @(negedge clk);

    // Start and stop together from IDLE: stop wins.
    pulseCtl(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("start_stop_busy", 32'(busy), 0);

    // Frame edge injected during FETCH.
    setTracks(16'd100, 16'd200, 16'd300, 16'd400);
    pulseCtl(1'b1, 1'b0);
    benchPos = '0;
    applyStimulus(16'd1000, 20'd1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a fetch.
    @(posedge clk);
    #1;
    frame = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_sample", 32'(sample), 0);
    checkOutput("midrst_valid", 32'(sampleValid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_pos", 32'(pos), 0);
    checkOutput("midrst_addr", 32'(sramAddr), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (sampleValid) seen++;
    end
    checkOutput("midrst_no_valid", seen, 0);
    frame = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
